// File: rtl/pe_vec_adder_if.sv
// Handshake and data bundle for pe_vec_adder: input beat side and output beat side.
// The slave modport is the adder's view; the master modport is the producer/consumer view.
interface pe_vec_adder_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] a;
    logic [LANES*WIDTH-1:0] b;
    logic                   sgn;
    logic                   sat;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] sum;
    logic [LANES-1:0]       ovf;

    modport master (
        output in_valid, a, b, sgn, sat, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, sgn, sat, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/pe_vec_adder.sv
// Multi-lane two-stage adder with per-beat signed/unsigned and wrap/saturate selection.
// Optional overflow-beat counter output ovf_cnt enabled by `define PE_VEC_ADDER_OVF_CNT_EN.
module pe_vec_adder #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    pe_vec_adder_if.slave bus
`ifdef PE_VEC_ADDER_OVF_CNT_EN
    ,
    output logic [15:0]   ovf_cnt
`endif
);

    logic                       advance;
    logic                       vld_p1;
    logic                       vld_p2;
    logic [LANES-1:0][WIDTH:0]  raw_d;
    logic [LANES-1:0][WIDTH:0]  raw_p1;
    logic                       sgn_p1;
    logic                       sat_p1;
    logic [LANES*WIDTH-1:0]     sum_p2;
    logic [LANES-1:0]           ovf_p2;

    function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                                     input logic is_sgn);
        return is_sgn ? $signed({v[WIDTH-1], v}) : $signed({1'b0, v});
    endfunction

    // Returns {ovf, result}; one extra bit of headroom makes overflow exact in both modes.
    function automatic logic [WIDTH:0] finish_lane(input logic [WIDTH:0] raw,
                                                   input logic is_sgn,
                                                   input logic is_sat);
        logic             o;
        logic [WIDTH-1:0] r;
        o = is_sgn ? (raw[WIDTH] ^ raw[WIDTH-1]) : raw[WIDTH];
        r = raw[WIDTH-1:0];
        if (is_sat && o) begin
            if (!is_sgn)
                r = '1;
            else if (!raw[WIDTH])
                r = {1'b0, {(WIDTH-1){1'b1}}};
            else
                r = {1'b1, {(WIDTH-1){1'b0}}};
        end
        return {o, r};
    endfunction

    assign advance       = en && (!vld_p2 || bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p2;
    assign bus.sum       = sum_p2;
    assign bus.ovf       = ovf_p2;

    always_comb begin
        raw_d = '0;
        for (int i = 0; i < LANES; i++)
            raw_d[i] = extend(bus.a[i*WIDTH +: WIDTH], bus.sgn)
                     + extend(bus.b[i*WIDTH +: WIDTH], bus.sgn);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= bus.in_valid;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: raw extended sums plus the beat's mode bits
    always_ff @(posedge clk) begin
        if (advance && bus.in_valid) begin
            raw_p1 <= raw_d;
            sgn_p1 <= bus.sgn;
            sat_p1 <= bus.sat;
        end
    end

    // Stage 2: final result and overflow, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_p2 <= '0;
            ovf_p2 <= '0;
        end else if (advance && vld_p1) begin
            for (int i = 0; i < LANES; i++)
                {ovf_p2[i], sum_p2[i*WIDTH +: WIDTH]} <= finish_lane(raw_p1[i], sgn_p1, sat_p1);
        end
    end

`ifdef PE_VEC_ADDER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            ovf_cnt <= '0;
        else if (en && vld_p2 && bus.out_ready && (|ovf_p2) && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/pe_vec_adder.md
Name: pe_vec_adder

Overview:
Multi-lane, parametrised successor to the PE scalar adder: LANES independent WIDTH-bit adds per beat, selectable signed/unsigned and wrap/saturate per beat, per-lane overflow flags. Two-stage registered pipeline with valid/ready handshake and a global clock-enable. Sits between the PE multiplier outputs and the accumulator/writeback path.

Parameters:
LANES, 4, number of parallel adder lanes
WIDTH, 8, bits per lane operand and result

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
en  in  1  global enable; 0 freezes all state, handshake outputs hold
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  LANES*WIDTH  operand A, lane i = a[i*WIDTH +: WIDTH]
b  in  LANES*WIDTH  operand B, same packing
sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the beat
sat  in  1  1 = saturate, 0 = wrap (truncate); sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
sum  out  LANES*WIDTH  per-lane result, same packing
ovf  out  LANES  per-lane overflow flag, aligned with sum

Behaviour:
- Reset (rst==0 at posedge): s1_valid=0, s2_valid=0, out_valid=0, sum=0, ovf=0. Reset overrides en. Beats in flight are discarded; no partial output.
- advance = en && (!s2_valid || out_ready). in_ready = advance (combinational).
- Input handshake: beat accepted when in_valid && in_ready.
- Stage 1 (on advance): s1_valid <= in_valid; when in_valid, register per-lane raw sum of (WIDTH+1) bits (zero-extend if sgn=0, sign-extend if sgn=1), plus sgn, sat.
- Stage 2 (on advance): s2_valid <= s1_valid; when s1_valid, register final sum/ovf from the stage-1 data.
- out_valid = s2_valid; sum/ovf are registered outputs, held stable while out_valid && !out_ready.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later with no stall; throughput 1 beat/cycle.
- Stall: out_valid && !out_ready freezes both stages (bubbles not squeezed); no beat lost or duplicated; order preserved.
- en==0: no state changes, in_ready=0, out_valid/sum/ovf hold.
- Overflow, unsigned: ovf = raw[WIDTH]. Signed: ovf = raw[WIDTH] ^ raw[WIDTH-1].
- Result: sat==0 or ovf==0 -> raw[WIDTH-1:0]. Unsigned saturate -> all ones. Signed saturate -> 2^(WIDTH-1)-1 if raw[WIDTH]==0 else -2^(WIDTH-1).
- ovf is reported in wrap mode as well.
- Lanes fully independent; no carry between lanes.

Optional Feature:
Macro PE_VEC_ADDER_OVF_CNT_EN.
- Defined: extra output port ovf_cnt out 16, counts output handshakes (out_valid && out_ready) where |ovf==1; saturates at 0xFFFF; cleared to 0 by reset; frozen when en==0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Unsigned wrap, WIDTH=8: lane0 a=0xF0 b=0x20 sgn=0 sat=0, accepted cycle T -> out_valid at T+2, sum lane0=0x10, ovf[0]=1; lane1 a=0x01 b=0x02 -> 0x03, ovf[1]=0.
- Saturation: unsigned 0xF0+0x20 sat=1 -> 0xFF ovf=1; signed 0x70+0x20 -> 0x7F ovf=1; signed 0x80+0xF0 -> 0x80 ovf=1; signed 0x10+0xF0 -> 0x00 ovf=0; mixed modes on back-to-back beats each use their own sgn/sat.
- Backpressure: stream 6 beats with lane0 a=k b=0 (k=1..6); hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, sum/ovf stable, outputs 1..6 in order, none dropped or repeated.
- Enable: en=0 for 4 cycles with two beats in flight -> no state change, in_ready=0, out_valid held; after en=1 both beats emerge in order with original latency remaining.
- Reset mid-stream: drive rst=0 one cycle while s1 and s2 valid -> next cycle out_valid=0, sum=0, ovf=0; first beat after release appears 2 cycles after acceptance.
- With PE_VEC_ADDER_OVF_CNT_EN: 5 handshaked beats, 3 with any lane overflowing, plus one overflowing beat held unaccepted (out_ready=0) -> ovf_cnt=3; after reset ovf_cnt=0.
